ysyx_22040228div_ctrl: RTL and testbench

- Execute-stage sequencer that sits directly upstream of the iterative divider and consumes its output.
- Accepts a DIV/DIVU/REM/REMU (and W-variant) request from the EXE datapath and conditions the operands for RV64 (32-bit extension for W ops).
- Resolves divide-by-zero and signed overflow locally, handshakes the divider, and stalls the pipeline until completion.
- Post-processes the divider result (W-op sign extension), presents a one-cycle result pulse, and drains a divider run orphaned by a pipeline flush.

---
 rtl/ysyx_22040228div_ctrl.sv | 100 ++++++++++
 tb/tb_ysyx_22040228div_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040228div_ctrl.sv
// ysyx_22040228div_ctrl: execute-stage sequencer for the iterative divider.
// Conditions RV64 operands, answers div-by-zero/overflow locally, stalls EXE and drains flushed runs.
module ysyx_22040228div_ctrl #(
  parameter int XLEN           = 64,
  parameter bit BYPASS_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_div_valid,
  input  logic [7:0]      ex_opcode,
  input  logic [XLEN-1:0] ex_rs1_data,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic            ex_flush,
  output logic            ex_stall_req,
  output logic [XLEN-1:0] ex_div_result,
  output logic            ex_div_result_valid,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_diviser,
  output logic [7:0]      div_opcode,
  output logic            div_ready,
  input  logic [XLEN-1:0] div_rem_data,
  input  logic            div_finish
);
  localparam logic [7:0] INST_DIV   = 8'h40;
  localparam logic [7:0] INST_DIVU  = 8'h41;
  localparam logic [7:0] INST_REM   = 8'h42;
  localparam logic [7:0] INST_REMU  = 8'h43;
  localparam logic [7:0] INST_DIVW  = 8'h44;
  localparam logic [7:0] INST_DIVUW = 8'h45;
  localparam logic [7:0] INST_REMW  = 8'h46;
  localparam logic [7:0] INST_REMUW = 8'h47;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_e;

  state_e          state_q;
  logic [XLEN-1:0] a_q, b_q, res_q;
  logic [7:0]      op_q;
  logic            is_div, is_w, is_rem, is_sgn, w_q;
  logic            b_zero, ovf, special, accept;
  logic [XLEN-1:0] a_d, b_d, spec_res, fin_res;

  always_comb begin
    is_div  = ex_opcode inside {INST_DIV, INST_DIVU, INST_REM, INST_REMU,
                                INST_DIVW, INST_DIVUW, INST_REMW, INST_REMUW};
    is_w    = ex_opcode inside {INST_DIVW, INST_DIVUW, INST_REMW, INST_REMUW};
    is_rem  = ex_opcode inside {INST_REM, INST_REMU, INST_REMW, INST_REMUW};
    is_sgn  = ex_opcode inside {INST_DIV, INST_REM, INST_DIVW, INST_REMW};
    w_q     = op_q inside {INST_DIVW, INST_DIVUW, INST_REMW, INST_REMUW};
    a_d     = !is_w ? ex_rs1_data : is_sgn ? {{(XLEN-32){ex_rs1_data[31]}}, ex_rs1_data[31:0]}
                                           : {{(XLEN-32){1'b0}}, ex_rs1_data[31:0]};
    b_d     = !is_w ? ex_rs2_data : is_sgn ? {{(XLEN-32){ex_rs2_data[31]}}, ex_rs2_data[31:0]}
                                           : {{(XLEN-32){1'b0}}, ex_rs2_data[31:0]};
    b_zero  = b_d == '0;
    ovf     = is_sgn && (is_w ? (a_d[31:0] == 32'h8000_0000 && b_d[31:0] == 32'hFFFF_FFFF)
                              : (a_d == {1'b1, {(XLEN-1){1'b0}}} && b_d == '1));
    special = BYPASS_SPECIAL && (b_zero || ovf);
    // W remainders are sign-extended even for REMUW, whose captured dividend is zero-extended
    spec_res = b_zero ? (is_rem ? (is_w ? {{(XLEN-32){a_d[31]}}, a_d[31:0]} : a_d) : '1)
                      : (is_rem ? '0 : a_d);
    fin_res = w_q ? {{(XLEN-32){div_rem_data[31]}}, div_rem_data[31:0]} : div_rem_data;
    accept  = rst && state_q == IDLE && ex_div_valid && is_div && !ex_flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          a_q     <= a_d;
          b_q     <= b_d;
          op_q    <= ex_opcode;
          res_q   <= special ? spec_res : res_q;
          state_q <= special ? RESP : ISSUE;
        end
        ISSUE: state_q <= ex_flush ? DRAIN : WAIT;
        WAIT: if (div_finish) begin
          res_q   <= ex_flush ? res_q : fin_res;
          state_q <= ex_flush ? IDLE : RESP;
        end else if (ex_flush) state_q <= DRAIN;
        RESP: state_q <= IDLE;
        DRAIN: if (div_finish) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex_stall_req        = accept || state_q == ISSUE || state_q == WAIT ||
                               (state_q == DRAIN && ex_div_valid && is_div);
  assign ex_div_result_valid = state_q == RESP && !ex_flush;
  assign ex_div_result       = res_q;
  assign div_ready           = state_q == ISSUE;
  assign div_dividend        = a_q;
  assign div_diviser         = b_q;
  assign div_opcode          = op_q;
endmodule

// File: tb/tb_ysyx_22040228div_ctrl.sv
// tb_ysyx_22040228div_ctrl: scoreboard bench with a behavioural divider that returns junk upper bits for W ops.
module tb_ysyx_22040228div_ctrl;
  localparam logic [7:0] DIV = 8'h40, DIVU = 8'h41, REM = 8'h42, REMU = 8'h43;
  localparam logic [7:0] DIVW = 8'h44, DIVUW = 8'h45, REMW = 8'h46, REMUW = 8'h47;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0, rst = 1'b0;
  logic        ex_div_valid = 1'b0, ex_flush = 1'b0;
  logic [7:0]  ex_opcode = 8'h0;
  logic [63:0] ex_rs1_data = '0, ex_rs2_data = '0;
  logic        ex_stall_req, ex_div_result_valid, div_ready;
  logic [63:0] ex_div_result, div_dividend, div_diviser;
  logic [7:0]  div_opcode;
  logic [63:0] div_rem_data;
  logic        div_finish;

  int          n_vec = 0, n_err = 0, ready_cnt = 0, pulse_cnt = 0, lat = 6;
  logic [63:0] exp_q[$];
  logic [63:0] last_dvd = '0, last_dvs = '0;

  ysyx_22040228div_ctrl dut (
    .clk(clk), .rst(rst), .ex_div_valid(ex_div_valid), .ex_opcode(ex_opcode),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_flush(ex_flush),
    .ex_stall_req(ex_stall_req), .ex_div_result(ex_div_result),
    .ex_div_result_valid(ex_div_result_valid), .div_dividend(div_dividend),
    .div_diviser(div_diviser), .div_opcode(div_opcode), .div_ready(div_ready),
    .div_rem_data(div_rem_data), .div_finish(div_finish));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] rv_ref(input logic [7:0] op, input logic [63:0] x, input logic [63:0] y);
    logic [63:0] r;
    logic [31:0] xw, yw, rw;
    xw = x[31:0];
    yw = y[31:0];
    r  = '0;
    rw = '0;
    case (op)
      DIV:   if (y == 0) r = '1; else if (x == MIN64 && y == '1) r = x; else r = $signed(x) / $signed(y);
      DIVU:  if (y == 0) r = '1; else r = x / y;
      REM:   if (y == 0) r = x; else if (x == MIN64 && y == '1) r = '0; else r = $signed(x) % $signed(y);
      REMU:  if (y == 0) r = x; else r = x % y;
      DIVW:  if (yw == 0) rw = '1; else if (xw == 32'h8000_0000 && yw == '1) rw = xw; else rw = $signed(xw) / $signed(yw);
      DIVUW: if (yw == 0) rw = '1; else rw = xw / yw;
      REMW:  if (yw == 0) rw = xw; else if (xw == 32'h8000_0000 && yw == '1) rw = '0; else rw = $signed(xw) % $signed(yw);
      REMUW: if (yw == 0) rw = xw; else rw = xw % yw;
      default: r = '0;
    endcase
    if (op inside {DIVW, DIVUW, REMW, REMUW}) r = {{32{rw[31]}}, rw};
    return r;
  endfunction

  function automatic logic [63:0] cond(input logic [7:0] op, input logic [63:0] v);
    if (op inside {DIVW, REMW}) return {{32{v[31]}}, v[31:0]};
    if (op inside {DIVUW, REMUW}) return {32'h0, v[31:0]};
    return v;
  endfunction

  always @(negedge clk) begin
    if (div_ready) begin
      ready_cnt++;
      last_dvd = div_dividend;
      last_dvs = div_diviser;
      chk("ready_vs_finish", 64'(div_finish), 64'd0);
    end
    if (ex_div_result_valid) begin
      pulse_cnt++;
      if (exp_q.size() == 0) chk("spurious_pulse", 64'd1, 64'd0);
      else chk("result", ex_div_result, exp_q.pop_front());
    end
  end

  initial begin
    logic [63:0] r;
    bit w;
    div_finish = 1'b0;
    div_rem_data = '0;
    forever begin
      @(negedge clk);
      if (div_ready) begin
        r = rv_ref(div_opcode, div_dividend, div_diviser);
        w = div_opcode inside {DIVW, DIVUW, REMW, REMUW};
        for (int i = 0; i < lat; i++) begin
          @(posedge clk);
          if (!rst) break;
        end
        if (rst) begin
          #1;
          div_finish = 1'b1;
          div_rem_data = w ? {32'hDEAD_BEEF, r[31:0]} : r;
          @(posedge clk);
          #1;
          div_finish = 1'b0;
          div_rem_data = '0;
        end
      end
    end
  end

  task automatic run_op(input logic [7:0] op, input logic [63:0] x, input logic [63:0] y, input bit spec);
    int r0, p0, cyc;
    r0 = ready_cnt;
    p0 = pulse_cnt;
    cyc = 0;
    @(posedge clk); #1;
    ex_div_valid = 1'b1;
    ex_opcode = op;
    ex_rs1_data = x;
    ex_rs2_data = y;
    exp_q.push_back(rv_ref(op, x, y));
    @(negedge clk);
    chk("stall_accept", 64'(ex_stall_req), 64'd1);
    do begin
      @(negedge clk);
      cyc++;
    end while (ex_stall_req && cyc < 300);
    chk("latency", 64'(cyc), 64'(spec ? 1 : lat + 2));
    @(posedge clk); #1;
    ex_div_valid = 1'b0;
    @(negedge clk);
    chk("ready_pulses", 64'(ready_cnt - r0), 64'(spec ? 0 : 1));
    chk("valid_pulses", 64'(pulse_cnt - p0), 64'd1);
    if (!spec) begin
      chk("dividend", last_dvd, cond(op, x));
      chk("diviser", last_dvs, cond(op, y));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, p0, cyc;
    #1;
    chk("rst_stall", 64'(ex_stall_req), 64'd0);
    chk("rst_valid", 64'(ex_div_result_valid), 64'd0);
    chk("rst_ready", 64'(div_ready), 64'd0);
    chk("rst_result", ex_div_result, 64'd0);
    chk("rst_dividend", div_dividend, 64'd0);
    chk("rst_diviser", div_diviser, 64'd0);
    chk("rst_opcode", 64'(div_opcode), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    run_op(DIVU, 64'd100, 64'd7, 1'b0);
    run_op(REMW, 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b0);
    run_op(DIV, 64'd5, 64'd0, 1'b1);
    run_op(REM, 64'd5, 64'd0, 1'b1);
    run_op(DIVW, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1);
    run_op(REMW, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1);
    run_op(DIV, MIN64, '1, 1'b1);
    run_op(REM, MIN64, '1, 1'b1);
    run_op(REMUW, 64'h0000_0000_8000_0001, 64'h1_0000_0000, 1'b1);
    run_op(DIVUW, 64'h1_0000_0010, 64'd3, 1'b0);
    run_op(DIV, -64'sd20, 64'd3, 1'b0);
    run_op(REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 1'b0);

    r0 = ready_cnt; p0 = pulse_cnt;
    @(posedge clk); #1;
    ex_div_valid = 1'b1; ex_opcode = 8'h13; ex_rs1_data = 64'd9; ex_rs2_data = 64'd0;
    @(negedge clk);
    chk("nondiv_stall", 64'(ex_stall_req), 64'd0);
    repeat (3) @(negedge clk);
    chk("nondiv_ready", 64'(ready_cnt - r0), 64'd0);
    chk("nondiv_pulse", 64'(pulse_cnt - p0), 64'd0);
    @(posedge clk); #1 ex_div_valid = 1'b0;

    lat = 20; r0 = ready_cnt; p0 = pulse_cnt; cyc = 0;
    @(posedge clk); #1;
    ex_div_valid = 1'b1; ex_opcode = DIV; ex_rs1_data = 64'd20; ex_rs2_data = 64'd3;
    repeat (5) @(negedge clk);
    chk("stall_wait", 64'(ex_stall_req), 64'd1);
    @(posedge clk); #1;
    ex_flush = 1'b1; ex_div_valid = 1'b0;
    @(negedge clk);
    chk("flush_no_pulse", 64'(ex_div_result_valid), 64'd0);
    @(posedge clk); #1;
    ex_flush = 1'b0; ex_div_valid = 1'b1; ex_opcode = DIVU; ex_rs1_data = 64'd9; ex_rs2_data = 64'd3;
    exp_q.push_back(64'd3);
    @(negedge clk);
    chk("stall_drain", 64'(ex_stall_req), 64'd1);
    do begin
      @(negedge clk);
      cyc++;
    end while (ex_stall_req && cyc < 300);
    chk("drain_done", 64'(ex_stall_req), 64'd0);
    @(posedge clk); #1 ex_div_valid = 1'b0;
    @(negedge clk);
    chk("drain_ready", 64'(ready_cnt - r0), 64'd2);
    chk("drain_pulse", 64'(pulse_cnt - p0), 64'd1);
    chk("drain_dividend", last_dvd, 64'd9);

    @(posedge clk); #1;
    ex_div_valid = 1'b1; ex_opcode = DIVU; ex_rs1_data = 64'd50; ex_rs2_data = 64'd5;
    repeat (4) @(negedge clk);
    #1;
    rst = 1'b0; ex_div_valid = 1'b0;
    #1;
    chk("arst_stall", 64'(ex_stall_req), 64'd0);
    chk("arst_valid", 64'(ex_div_result_valid), 64'd0);
    chk("arst_ready", 64'(div_ready), 64'd0);
    chk("arst_result", ex_div_result, 64'd0);
    chk("arst_dividend", div_dividend, 64'd0);
    chk("arst_diviser", div_diviser, 64'd0);
    chk("arst_opcode", 64'(div_opcode), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    lat = 6;
    run_op(DIVU, 64'd8, 64'd2, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
